// File: rtl/micro_pkg.sv
// Shared definitions for the program-memory fetch responder.
//   - default address/data/index widths
//   - FSM state encodings (legacy two-bit values)
//   - hold/miss counter widths and saturating-increment helpers
package micro_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned INDEX_W_DEF = 3;

    localparam int unsigned HOLD_CNT_W = 3;
    localparam int unsigned MISS_CNT_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    function automatic logic [HOLD_CNT_W-1:0] hold_cnt_inc(input logic [HOLD_CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    function automatic logic [MISS_CNT_W-1:0] miss_cnt_inc(input logic [MISS_CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/pm_icache_responder_if.sv
// Program-memory fetch/hold bus plus backing-ROM handshake.
//   Fetch side : pm_address (to responder), pm_data, hold, start_hold,
//                end_hold, hold_count (from responder)
//   ROM side   : mem_req, mem_addr (from responder), mem_ack, mem_data
//                (to responder)
//   Statistics : miss_count (from responder)
// slave  = the cache responder; master = the micro plus ROM environment.
interface pm_icache_responder_if #(
    parameter int unsigned ADDR_W = micro_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = micro_pkg::DATA_W_DEF
);
    import micro_pkg::*;

    logic [ADDR_W-1:0]     pm_address;
    logic [DATA_W-1:0]     pm_data;
    logic                  hold;
    logic                  start_hold;
    logic                  end_hold;
    logic [HOLD_CNT_W-1:0] hold_count;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_data;
    logic [MISS_CNT_W-1:0] miss_count;

    modport slave (
        input  pm_address, mem_ack, mem_data,
        output pm_data, hold, start_hold, end_hold, hold_count,
               mem_req, mem_addr, miss_count
    );

    modport master (
        output pm_address, mem_ack, mem_data,
        input  pm_data, hold, start_hold, end_hold, hold_count,
               mem_req, mem_addr, miss_count
    );

endinterface

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: one valid bit, tag and data byte per line.
//   clk        rising-edge clock
//   clr_i      synchronous clear of every line (valid, tag, data -> 0)
//   rd_idx_i   combinational read index; rd_valid_o/rd_tag_o/rd_data_o
//   wr_en_i    single write port: sets valid and stores wr_tag_i/wr_data_i
//              at wr_idx_i
module icache_line_array #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned DATA_W  = 8
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i
);

    localparam int unsigned NUM_LINES = 1 << INDEX_W;

    logic              valid_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [DATA_W-1:0] data_q  [NUM_LINES];

    // Clear has priority so a write racing a reset is dropped.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
            data_q[wr_idx_i]  <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/pm_icache_responder.sv
// Responder side of the micro's program-memory fetch/hold interface.
// Serves pm_data from a direct-mapped one-byte-per-line cache; on a miss it
// raises hold, reads the byte from the backing ROM over mem_req/mem_ack,
// fills the line and releases hold.
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   pm_bus  slave modport: pm_address in, pm_data/hold/start_hold/end_hold/
//           hold_count out; mem_req/mem_addr out, mem_ack/mem_data in;
//           miss_count out
module pm_icache_responder
    import micro_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    pm_icache_responder_if.slave  pm_bus
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;

    logic [1:0]            state_q,      state_d;
    logic [ADDR_W-1:0]     miss_addr_q,  miss_addr_d;
    logic [HOLD_CNT_W-1:0] hold_count_q, hold_count_d;
    logic [MISS_CNT_W-1:0] miss_count_q, miss_count_d;

    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;

    logic hold, start_hold, end_hold, mem_req, wr_en;

    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk        (clk),
        .clr_i      (reset),
        .rd_idx_i   (pm_bus.pm_address[INDEX_W-1:0]),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (miss_addr_q[INDEX_W-1:0]),
        .wr_tag_i   (miss_addr_q[ADDR_W-1:INDEX_W]),
        .wr_data_i  (pm_bus.mem_data)
    );

    assign hit = line_valid && (line_tag == pm_bus.pm_address[ADDR_W-1:INDEX_W]);

    // hold is combinational in IDLE so the micro stalls in the miss cycle.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        hold        = 1'b0;
        start_hold  = 1'b0;
        end_hold    = 1'b0;
        mem_req     = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    hold        = 1'b1;
                    start_hold  = 1'b1;
                    miss_addr_d = pm_bus.pm_address;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                hold    = 1'b1;
                mem_req = 1'b1;
                if (pm_bus.mem_ack) begin
                    wr_en   = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                hold     = 1'b1;
                end_hold = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are masked for the whole reset period, so a
        // reset that lands mid-REQ drops the request in the same cycle.
        if (reset) begin
            hold       = 1'b0;
            start_hold = 1'b0;
            end_hold   = 1'b0;
            mem_req    = 1'b0;
            wr_en      = 1'b0;
        end
    end

    // hold_count restarts at 0 after the start_hold cycle and then counts
    // every further hold cycle; its final value is (hold cycles - 1).
    always_comb begin
        hold_count_d = hold_count_q;
        miss_count_d = miss_count_q;
        if (start_hold) begin
            hold_count_d = '0;
            miss_count_d = miss_cnt_inc(miss_count_q);
        end else if (hold) begin
            hold_count_d = hold_cnt_inc(hold_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            miss_addr_q  <= '0;
            hold_count_q <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            hold_count_q <= hold_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign pm_bus.pm_data    = line_data;
    assign pm_bus.hold       = hold;
    assign pm_bus.start_hold = start_hold;
    assign pm_bus.end_hold   = end_hold;
    assign pm_bus.hold_count = hold_count_q;
    assign pm_bus.mem_req    = mem_req;
    assign pm_bus.mem_addr   = miss_addr_q;
    assign pm_bus.miss_count = miss_count_q;

endmodule

// File: doc/pm_icache_responder.md
Name: pm_icache_responder

Overview:
- Responder side of the program-memory fetch/hold interface used by `micro`.
- Presents `pm_data` for the micro's `pm_address` from a small direct-mapped instruction cache.
- On a miss, asserts `hold` to stall the micro, fetches the byte from a slow backing program ROM over a req/ack handshake, fills the line, then releases `hold`.
- Produces the `hold`/`start_hold`/`end_hold`/`hold_count` observation signals the micro forwards to its testbench.

Parameters:
- ADDR_W, 8, width of `pm_address` and `mem_addr`.
- DATA_W, 8, instruction byte width.
- INDEX_W, 3, line index bits (2^INDEX_W lines, one byte per line); TAG_W = ADDR_W - INDEX_W is a localparam.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pm_address  in  ADDR_W  fetch address from micro PC logic.
- pm_data  out  DATA_W  instruction byte to micro `ir` path.
- hold  out  1  stall request to micro.
- start_hold  out  1  one-cycle pulse on first hold cycle of a miss.
- end_hold  out  1  one-cycle pulse on last hold cycle of a miss.
- hold_count  out  3  hold cycles elapsed in current/last miss, saturating.
- mem_req  out  1  backing ROM read request.
- mem_addr  out  ADDR_W  backing ROM read address.
- mem_ack  in  1  backing ROM data valid, single-cycle.
- mem_data  in  DATA_W  backing ROM read data.
- miss_count  out  8  saturating miss counter.

Behaviour:
- Single clock `clk`; reset is synchronous and active-high on `reset`.
- Storage: per line a valid bit, TAG_W tag and DATA_W data.
  - index = pm_address[INDEX_W-1:0]; tag = upper bits.
  - hit = valid[index] && tag match.
- pm_data: combinational read of data[index]. Value is don't-care on miss but must not be X after reset (data arrays reset to 0).
- FSM states: IDLE, REQ, FILL.
  - IDLE:
    - hit: hold=0, stay.
    - miss and not reset: hold=1, start_hold=1, latch pm_address into miss_addr, go to REQ.
    - hold is combinational in IDLE so the micro stalls in the miss cycle itself.
  - REQ:
    - hold=1, mem_req=1, mem_addr=miss_addr.
    - On mem_ack: write mem_data, tag and valid=1 into line miss_addr index, go to FILL.
    - mem_req deasserts in the cycle after ack.
  - FILL: hold=1, end_hold=1, go to IDLE. The next IDLE cycle hits (zero-latency).
- Minimum miss penalty: miss cycle + 1 REQ cycle (ack same cycle) + FILL = 3 hold cycles.
- pm_address changes while in REQ/FILL are ignored; only miss_addr is fetched. If the address differs on return to IDLE, a new miss starts normally.
- mem_ack while in IDLE or FILL: ignored (no write, no state change).
- hold_count (registered):
  - Cleared to 0 on the start_hold cycle.
  - +1 each subsequent cycle hold is high; saturates at 7.
  - Holds its value after end_hold until the next miss.
- miss_count: +1 on each start_hold, saturates at 255.
- Reset (any state, including mid-REQ):
  - Next state IDLE; all valid bits 0; data/tags 0.
  - miss_addr 0, hold_count 0, miss_count 0.
  - mem_req 0; hold/start_hold/end_hold forced 0 while reset is high.
  - A late mem_ack after reset is ignored.
- First non-reset cycle after reset with any address is a cold miss.

Decomposition:
- Shared package `micro_pkg`:
  - ADDR_W/DATA_W defaults.
  - FSM state encoding localparams (S_IDLE=2'd0, S_REQ=2'd1, S_FILL=2'd2).
  - HOLD_CNT_W=3.
- Sub-module `icache_line_array`: valid/tag/data storage with combinational read port, single write port, and synchronous clear. FSM, counters and handshake stay in `pm_icache_responder`.

Test Plan:
- Cold miss: reset 3 cycles, pm_address=0x00, ROM acks 2 cycles after mem_req with 0xA5 -> hold high 4 cycles, start_hold pulse at cycle 0, end_hold pulse in FILL, hold_count=3, pm_data=0xA5 with hold=0 the next cycle, miss_count=1.
- Hit: re-present 0x00 after fill -> hold=0 same cycle, pm_data=0xA5, mem_req never asserted, miss_count unchanged.
- Conflict: fetch 0x08 (same index 0, different tag) with ROM data 0x3C -> miss, line replaced; then 0x00 misses again -> miss_count=3.
- Address change mid-miss: miss on 0x12, switch pm_address to 0x13 during REQ -> mem_addr stays 0x12; after FILL, 0x13 starts a new miss with start_hold pulse.
- Saturation: ROM ack delayed 10 cycles -> hold_count reaches 7 and stays 7 through end_hold; hold stays high until FILL completes.
- Reset mid-REQ: assert reset during REQ, then ROM acks -> state IDLE, mem_req=0, hold=0 during reset, all lines invalid, no write occurs, next fetch of 0x12 is a miss.
